// File: rtl/prbs_checker_pkg.sv
// Shared types and constants for the self-synchronising PRBS checker.
package prbs_pkg;

  typedef enum logic [1:0] {
    FILL,
    SYNC,
    LOCKED
  } prbs_state_t;

  localparam logic [47:0] PRBS48_TAPS = 48'h8000_0000_005C;

  localparam int unsigned ERRORS_W = 32;

endpackage

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker: fills history, syncs, locks, then counts errors against a local reference.
// Optional saturating error counter: define PRBS_CHECKER_ERRCNT_EN.
module prbs_checker #(
  parameter int unsigned       Length    = 48,
  parameter logic [Length-1:0] Taps      = Length'(prbs_pkg::PRBS48_TAPS),
  parameter int unsigned       LockCount = 16,
  parameter int unsigned       LossCount = 8
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          IE,
  input  logic                          IN,
  output logic                          LOCKED,
  output logic                          ERR,
  output logic [prbs_pkg::ERRORS_W-1:0] ERRORS
);

  localparam int unsigned FillW = $clog2(Length + 1);
  localparam int unsigned RunW  = $clog2(LockCount + 1);
  localparam int unsigned LossW = $clog2(LossCount + 1);

  prbs_pkg::prbs_state_t state;
  logic [Length-1:0]     hist;
  logic [FillW-1:0]      fill_cnt;
  logic [RunW-1:0]       run_cnt;
  logic [LossW-1:0]      loss_cnt;
  logic                  locked_q;
  logic                  err_q;

  logic pred_c;
  logic miss_c;

  assign pred_c = ^(hist & Taps);
  assign miss_c = IN ^ pred_c;

  // Once locked, the history runs on its own predictions so a line error shows up once.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= prbs_pkg::FILL;
      hist     <= '0;
      fill_cnt <= '0;
      run_cnt  <= '0;
      loss_cnt <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (IE) begin
        case (state)
          prbs_pkg::FILL: begin
            hist <= {hist[Length-2:0], IN};
            if (fill_cnt == FillW'(Length - 1)) begin
              state    <= prbs_pkg::SYNC;
              fill_cnt <= '0;
              run_cnt  <= '0;
            end else begin
              fill_cnt <= fill_cnt + FillW'(1);
            end
          end
          prbs_pkg::SYNC: begin
            hist <= {hist[Length-2:0], IN};
            if (miss_c) begin
              run_cnt <= '0;
            end else if (run_cnt == RunW'(LockCount - 1)) begin
              state    <= prbs_pkg::LOCKED;
              locked_q <= 1'b1;
              run_cnt  <= '0;
              loss_cnt <= '0;
            end else begin
              run_cnt <= run_cnt + RunW'(1);
            end
          end
          prbs_pkg::LOCKED: begin
            hist <= {hist[Length-2:0], pred_c};
            if (miss_c) begin
              err_q   <= 1'b1;
              run_cnt <= '0;
              if (loss_cnt == LossW'(LossCount - 1)) begin
                state    <= prbs_pkg::FILL;
                locked_q <= 1'b0;
                fill_cnt <= '0;
                loss_cnt <= '0;
              end else begin
                loss_cnt <= loss_cnt + LossW'(1);
              end
            end else if (run_cnt == RunW'(LockCount - 1)) begin
              run_cnt  <= '0;
              loss_cnt <= '0;
            end else begin
              run_cnt <= run_cnt + RunW'(1);
            end
          end
          default: begin
            state    <= prbs_pkg::FILL;
            locked_q <= 1'b0;
            fill_cnt <= '0;
          end
        endcase
      end
    end
  end

  assign LOCKED = locked_q;
  assign ERR    = err_q;

`ifdef PRBS_CHECKER_ERRCNT_EN
  logic [prbs_pkg::ERRORS_W-1:0] errors_q;

  // Saturating count of locked-state mismatches; survives relock.
  always_ff @(posedge CLK) begin
    if (RST) begin
      errors_q <= '0;
    end else if (IE && (state == prbs_pkg::LOCKED) && miss_c && (errors_q != '1)) begin
      errors_q <= errors_q + prbs_pkg::ERRORS_W'(1);
    end
  end

  assign ERRORS = errors_q;
`else
  assign ERRORS = '0;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Randomised self-checking bench for prbs_checker against a queue-based behavioural model.
module tb_prbs_checker;

  localparam int unsigned LEN    = 48;
  localparam int unsigned LOCK_N = 16;
  localparam int unsigned LOSS_N = 8;
  localparam logic [47:0] TAPS   = 48'h8000_0000_005C;
  localparam logic [47:0] SEED   = 48'hA1EA_1AC7_AE57;
`ifdef PRBS_CHECKER_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        IE  = 1'b0;
  logic        IN  = 1'b0;
  logic        LOCKED;
  logic        ERR;
  logic [31:0] ERRORS;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  prbs_checker dut (
    .CLK   (CLK),
    .RST   (RST),
    .IE    (IE),
    .IN    (IN),
    .LOCKED(LOCKED),
    .ERR   (ERR),
    .ERRORS(ERRORS)
  );

  // Reference generator: Fibonacci LFSR, newest bit in bit 0.
  logic [47:0] g;
  function automatic bit gen_next();
    bit b;
    b = ^(g & TAPS);
    g = {g[46:0], b};
    return b;
  endfunction

  // Behavioural checker model: mq[0] is the newest history bit.
  bit          mq[$];
  int          m_mode;  // 0 fill, 1 sync, 2 locked
  int          m_fill, m_run, m_loss;
  bit          m_locked, m_err;
  logic [31:0] m_errors;

  function automatic bit m_pred();
    bit p = 1'b0;
    for (int i = 0; i < LEN; i++) if (TAPS[i]) p ^= mq[i];
    return p;
  endfunction

  function automatic void m_push(bit b);
    mq.push_front(b);
    void'(mq.pop_back());
  endfunction

  function automatic void model_reset();
    mq.delete();
    for (int i = 0; i < LEN; i++) mq.push_back(1'b0);
    m_mode = 0; m_fill = 0; m_run = 0; m_loss = 0;
    m_locked = 1'b0; m_err = 1'b0; m_errors = 32'd0;
  endfunction

  function automatic void model_step(bit ie, bit b);
    bit p;
    m_err = 1'b0;
    if (!ie) return;
    p = m_pred();
    case (m_mode)
      0: begin
        m_push(b);
        m_fill++;
        if (m_fill == LEN) begin m_mode = 1; m_fill = 0; m_run = 0; end
      end
      1: begin
        m_push(b);
        if (b == p) begin
          m_run++;
          if (m_run == LOCK_N) begin m_mode = 2; m_run = 0; m_loss = 0; end
        end else m_run = 0;
      end
      default: begin
        m_push(p);
        if (b != p) begin
          m_err = 1'b1;
          m_run = 0;
          m_loss++;
          if (CNT_EN && m_errors != 32'hFFFF_FFFF) m_errors++;
          if (m_loss == LOSS_N) begin m_mode = 0; m_fill = 0; m_loss = 0; end
        end else begin
          m_run++;
          if (m_run == LOCK_N) begin m_run = 0; m_loss = 0; end
        end
      end
    endcase
    m_locked = (m_mode == 2);
  endfunction

  task automatic drive(input bit ie, input bit b);
    @(negedge CLK);
    RST = 1'b0; IE = ie; IN = b;
    model_step(ie, b);
    @(posedge CLK); #1;
  endtask

  // IE and IN are held high during reset to show they are ignored.
  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1; IE = 1'b1; IN = 1'b1;
    model_reset();
    @(posedge CLK); #1;
  endtask

  task automatic lock_up();
    do_reset();
    repeat (LEN + LOCK_N) drive(1'b1, gen_next());
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (LOCKED !== 1'b0) begin fails++; $display("FAIL reset_locked got %b want 0", LOCKED); end
    tests++; if (ERR !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", ERR); end
    tests++; if (ERRORS !== 32'd0) begin fails++; $display("FAIL reset_errors got %h want 0", ERRORS); end
  endtask

  task automatic test_clean_lock();
    int errs = 0;
    do_reset();
    g = SEED;
    for (int n = 1; n <= 10000; n++) begin
      drive(1'b1, gen_next());
      tests++;
      if (LOCKED !== m_locked || ERR !== m_err || ERRORS !== m_errors) begin
        fails++; $display("FAIL clean bit %0d got %b/%b/%h want %b/%b/%h", n, LOCKED, ERR, ERRORS, m_locked, m_err, m_errors);
      end
      if (ERR === 1'b1) errs++;
      if (n == 63) begin tests++; if (LOCKED !== 1'b0) begin fails++; $display("FAIL clean_bit63 LOCKED got %b want 0", LOCKED); end end
      if (n == 64) begin tests++; if (LOCKED !== 1'b1) begin fails++; $display("FAIL clean_bit64 LOCKED got %b want 1", LOCKED); end end
    end
    tests++; if (errs != 0) begin fails++; $display("FAIL clean_err_pulses got %0d want 0", errs); end
    tests++; if (ERRORS !== 32'd0) begin fails++; $display("FAIL clean_errors got %h want 0", ERRORS); end
  endtask

  task automatic test_single_error();
    int errs = 0;
    bit b;
    lock_up();
    for (int n = 1; n <= 600; n++) begin
      b = gen_next();
      if (n == 500) b = ~b;
      drive(1'b1, b);
      tests++;
      if (LOCKED !== m_locked || ERR !== m_err || ERRORS !== m_errors) begin
        fails++; $display("FAIL single bit %0d got %b/%b/%h want %b/%b/%h", n, LOCKED, ERR, ERRORS, m_locked, m_err, m_errors);
      end
      tests++; if (ERR !== (n == 500)) begin fails++; $display("FAIL single_err_timing bit %0d got %b want %b", n, ERR, (n == 500)); end
      if (ERR === 1'b1) errs++;
    end
    tests++; if (errs != 1) begin fails++; $display("FAIL single_err_pulses got %0d want 1", errs); end
    tests++; if (LOCKED !== 1'b1) begin fails++; $display("FAIL single_locked got %b want 1", LOCKED); end
    tests++; if (ERRORS !== (CNT_EN ? 32'd1 : 32'd0)) begin fails++; $display("FAIL single_errors got %h want %h", ERRORS, (CNT_EN ? 32'd1 : 32'd0)); end
  endtask

  task automatic test_loss_of_lock();
    int errs = 0;
    bit b;
    lock_up();
    repeat (20) drive(1'b1, gen_next());
    for (int k = 0; k < 32; k++) begin
      b = gen_next();
      if (k % 4 == 0) b = ~b;
      drive(1'b1, b);
      tests++;
      if (LOCKED !== m_locked || ERR !== m_err || ERRORS !== m_errors) begin
        fails++; $display("FAIL loss k %0d got %b/%b/%h want %b/%b/%h", k, LOCKED, ERR, ERRORS, m_locked, m_err, m_errors);
      end
      if (ERR === 1'b1) errs++;
      if (k == 24) begin tests++; if (LOCKED !== 1'b1) begin fails++; $display("FAIL loss_7th LOCKED got %b want 1", LOCKED); end end
      if (k == 28) begin tests++; if (LOCKED !== 1'b0 || ERR !== 1'b1) begin fails++; $display("FAIL loss_8th LOCKED/ERR got %b/%b want 0/1", LOCKED, ERR); end end
    end
    // Three bits already accepted in fill after the drop; relock needs 64 in total.
    for (int n = 1; n <= 100; n++) begin
      drive(1'b1, gen_next());
      tests++;
      if (LOCKED !== ((3 + n) >= 64) || ERR !== 1'b0) begin
        fails++; $display("FAIL relock bit %0d LOCKED/ERR got %b/%b want %b/0", n, LOCKED, ERR, ((3 + n) >= 64));
      end
    end
    tests++; if (errs != 8) begin fails++; $display("FAIL loss_err_pulses got %0d want 8", errs); end
    tests++; if (ERRORS !== (CNT_EN ? 32'd8 : 32'd0)) begin fails++; $display("FAIL loss_errors got %h want %h", ERRORS, (CNT_EN ? 32'd8 : 32'd0)); end
  endtask

  task automatic test_ie_gaps();
    int acc = 0;
    int cyc = 0;
    bit ie, b;
    do_reset();
    while (acc < 100 && cyc < 2000) begin
      ie = 1'($urandom_range(0, 1));
      b  = ie ? gen_next() : 1'($urandom_range(0, 1));
      drive(ie, b);
      cyc++;
      if (ie) acc++;
      tests++;
      if (LOCKED !== m_locked || ERR !== m_err || ERRORS !== m_errors) begin
        fails++; $display("FAIL ie_model cyc %0d got %b/%b/%h want %b/%b/%h", cyc, LOCKED, ERR, ERRORS, m_locked, m_err, m_errors);
      end
      tests++;
      if (LOCKED !== (acc >= 64) || ERR !== 1'b0) begin
        fails++; $display("FAIL ie_lock acc %0d LOCKED/ERR got %b/%b want %b/0", acc, LOCKED, ERR, (acc >= 64));
      end
    end
    tests++; if (acc < 100) begin fails++; $display("FAIL ie_budget accepted %0d want 100", acc); end
  endtask

  task automatic test_mid_reset();
    bit b;
    lock_up();
    for (int n = 1; n <= 30; n++) begin
      b = gen_next();
      if (n == 10) b = ~b;
      drive(1'b1, b);
    end
    do_reset();
    tests++;
    if (LOCKED !== 1'b0 || ERR !== 1'b0 || ERRORS !== 32'd0) begin
      fails++; $display("FAIL midrst got %b/%b/%h want 0/0/0", LOCKED, ERR, ERRORS);
    end
    for (int n = 1; n <= 70; n++) begin
      drive(1'b1, gen_next());
      tests++;
      if (LOCKED !== (n >= 64) || ERR !== m_err || ERRORS !== m_errors) begin
        fails++; $display("FAIL midrst_relock bit %0d got %b/%b/%h want %b/%b/%h", n, LOCKED, ERR, ERRORS, (n >= 64), m_err, m_errors);
      end
    end
  endtask

  task automatic test_slip();
    int  errs = 0;
    bit  dropped = 1'b0;
    bit  drop_err = 1'b0;
    lock_up();
    drive(1'b1, 1'($urandom_range(0, 1)));
    for (int n = 1; n <= 1000; n++) begin
      drive(1'b1, gen_next());
      tests++;
      if (LOCKED !== m_locked || ERR !== m_err || ERRORS !== m_errors) begin
        fails++; $display("FAIL slip bit %0d got %b/%b/%h want %b/%b/%h", n, LOCKED, ERR, ERRORS, m_locked, m_err, m_errors);
      end
      if (!dropped && ERR === 1'b1) errs++;
      if (!dropped && LOCKED === 1'b0) begin dropped = 1'b1; drop_err = ERR; end
    end
    tests++; if (!dropped) begin fails++; $display("FAIL slip_drop got no drop want drop"); end
    tests++; if (drop_err !== 1'b1 || errs < int'(LOSS_N)) begin fails++; $display("FAIL slip_drop_err err %b pulses %0d want 1 and >=8", drop_err, errs); end
    tests++; if (LOCKED !== 1'b1) begin fails++; $display("FAIL slip_relock got %b want 1", LOCKED); end
  endtask

  task automatic test_all_zero();
    do_reset();
    for (int n = 1; n <= 80; n++) begin
      drive(1'b1, 1'b0);
      tests++;
      if (LOCKED !== (n >= 64) || ERR !== 1'b0) begin
        fails++; $display("FAIL zero bit %0d LOCKED/ERR got %b/%b want %b/0", n, LOCKED, ERR, (n >= 64));
      end
    end
  endtask

`ifdef PRBS_CHECKER_ERRCNT_EN
  task automatic test_saturation();
    bit b;
    lock_up();
    @(negedge CLK);
    force dut.errors_q = 32'hFFFF_FFFE;
    #1 release dut.errors_q;
    m_errors = 32'hFFFF_FFFE;
    for (int k = 0; k < 12; k++) begin
      b = gen_next();
      if (k % 4 == 0) b = ~b;
      drive(1'b1, b);
      tests++;
      if (ERRORS !== m_errors || ERR !== m_err) begin
        fails++; $display("FAIL sat k %0d ERRORS/ERR got %h/%b want %h/%b", k, ERRORS, ERR, m_errors, m_err);
      end
    end
    tests++; if (ERRORS !== 32'hFFFF_FFFF) begin fails++; $display("FAIL sat_final got %h want ffffffff", ERRORS); end
  endtask
`endif

  initial begin
    model_reset();
    g = SEED;
    test_reset();
    test_clean_lock();
    test_single_error();
    test_loss_of_lock();
    test_ie_gaps();
    test_mid_reset();
    test_slip();
    test_all_zero();
`ifdef PRBS_CHECKER_ERRCNT_EN
    test_saturation();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
